// File: rtl/t_block_pkg.sv
// t_block_pkg: shared types and helpers for the DH link-transform block
package t_block_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} prod_e;

    // Operand register slots; the order matches the latch concatenation in the top
    typedef enum logic [2:0] {OP_A, OP_D, OP_CT, OP_ST, OP_CA, OP_SA} opnd_e;

    typedef struct packed {
        opnd_e a_sel;
        opnd_e b_sel;
    } op_pair_t;

    localparam int NUM_PROD = 6;
    localparam int NUM_OPND = 6;

    function automatic op_pair_t op_pair(prod_e p);
        op_pair_t r;
        case (p)
            P0:      r = '{OP_ST, OP_CA};
            P1:      r = '{OP_ST, OP_SA};
            P2:      r = '{OP_A,  OP_CT};
            P3:      r = '{OP_CT, OP_CA};
            P4:      r = '{OP_CT, OP_SA};
            default: r = '{OP_A,  OP_ST};
        endcase
        return r;
    endfunction

    function automatic logic [63:0] one_val(int frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/t_block_issue_sched.sv
// t_block_issue_sched: issue-group counter and result valid/tag pipe matching the multiplier latency
module t_block_issue_sched #(
    parameter int NUM_MULT = 6,
    parameter int MULT_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       issue,
    output logic [2:0] grp,
    output logic       last_issue,
    output logic       cap_vld,
    output logic [2:0] cap_grp,
    output logic       last_cap
);

    localparam int NG = 6 / NUM_MULT;
    localparam int TW = 3 * MULT_LAT;
    localparam logic [2:0] LAST = 3'(NG - 1);

    logic [2:0]          grp_q, grp_d;
    logic [MULT_LAT-1:0] vld_q, vld_d;
    logic [TW-1:0]       tag_q, tag_d;

    // step through the groups while issuing and push each group's tag down the latency pipe
    always_comb begin
        grp_d = issue ? (grp_q == LAST ? 3'd0 : grp_q + 3'd1) : 3'd0;
        vld_d = (vld_q << 1) | MULT_LAT'(issue);
        tag_d = (tag_q << 3) | TW'(grp_q);
    end

    // counter and pipe freeze with en so they stay aligned with the stalled multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q <= '0;
            vld_q <= '0;
            tag_q <= '0;
        end else if (en) begin
            grp_q <= grp_d;
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign grp        = grp_q;
    assign last_issue = issue && grp_q == LAST;
    assign cap_vld    = vld_q[MULT_LAT-1];
    assign cap_grp    = tag_q[TW-1 -: 3];
    assign last_cap   = cap_vld && cap_grp == LAST;

endmodule

// File: rtl/t_block_param.sv
// t_block_param: DH link transform built on a time-multiplexed external multiplier
module t_block_param
    import t_block_pkg::*;
#(
    parameter int W        = 36,
    parameter int FRAC     = 16,
    parameter int NUM_MULT = 6,
    parameter int MULT_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [W-1:0]                 a,
    input  logic [W-1:0]                 d,
    input  logic [W-1:0]                 cos_theta,
    input  logic [W-1:0]                 sin_theta,
    input  logic [W-1:0]                 cos_alpha,
    input  logic [W-1:0]                 sin_alpha,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_MULT-1:0][W-1:0]   mult_dataa,
    output logic [NUM_MULT-1:0][W-1:0]   mult_datab,
    input  logic [NUM_MULT-1:0][W-1:0]   mult_result,
    output logic [3:0][3:0][W-1:0]       t_matrix
);

    if (NUM_MULT != 1 && NUM_MULT != 2 && NUM_MULT != 3 && NUM_MULT != 6) begin : g_bad_lanes
        $error("NUM_MULT must be 1, 2, 3 or 6");
    end
    if (MULT_LAT < 1) begin : g_bad_lat
        $error("MULT_LAT must be at least 1");
    end

    localparam logic [63:0]  ONE64 = one_val(FRAC);
    localparam logic [W-1:0] ONE   = ONE64[W-1:0];

    state_e                        state_q, state_d;
    logic [NUM_OPND-1:0][W-1:0]    opnd_q, opnd_d;
    logic [NUM_PROD-1:0][W-1:0]    stg_q, stg_d;
    logic [3:0][3:0][W-1:0]        t_q, t_d;
    logic [2:0]                    grp, cap_grp;
    logic                          last_issue, cap_vld, last_cap;
    logic                          issue, accept;

    assign issue  = state_q == ISSUE;
    assign accept = state_q == IDLE && start;

    t_block_issue_sched #(
        .NUM_MULT (NUM_MULT),
        .MULT_LAT (MULT_LAT)
    ) u_sched (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .issue      (issue),
        .grp        (grp),
        .last_issue (last_issue),
        .cap_vld    (cap_vld),
        .cap_grp    (cap_grp),
        .last_cap   (last_cap)
    );

    // sequencing: accept start only in IDLE, drain until the last group lands, one DONE cycle
    always_comb begin
        state_d = state_q == IDLE  ? (start      ? ISSUE : IDLE)  :
                  state_q == ISSUE ? (last_issue ? DRAIN : ISSUE) :
                  state_q == DRAIN ? (last_cap   ? DONE  : DRAIN) : IDLE;
    end

    // operand latch, product staging, and whole-matrix load on the final capture
    always_comb begin
        opnd_d = accept ? {sin_alpha, cos_alpha, sin_theta, cos_theta, d, a} : opnd_q;
        stg_d  = stg_q;
        for (int p = 0; p < NUM_PROD; p++)
            if (cap_vld && cap_grp == 3'(p / NUM_MULT)) stg_d[p] = mult_result[p % NUM_MULT];
        t_d = t_q;
        if (state_q == DRAIN && last_cap) begin
            t_d[0] = {stg_d[P2], stg_d[P1], -stg_d[P0], opnd_q[OP_CT]};
            t_d[1] = {stg_d[P5], -stg_d[P4], stg_d[P3], opnd_q[OP_ST]};
            t_d[2] = {opnd_q[OP_D], opnd_q[OP_CA], opnd_q[OP_SA], {W{1'b0}}};
            t_d[3] = {ONE, {(3*W){1'b0}}};
        end
    end

    // drive the current group's operand pairs onto the lanes, zero outside ISSUE
    always_comb begin
        op_pair_t op;
        op         = '0;
        mult_dataa = '0;
        mult_datab = '0;
        for (int p = 0; p < NUM_PROD; p++) begin
            op = op_pair(prod_e'(p));
            if (issue && grp == 3'(p / NUM_MULT)) begin
                mult_dataa[p % NUM_MULT] = opnd_q[op.a_sel];
                mult_datab[p % NUM_MULT] = opnd_q[op.b_sel];
            end
        end
    end

    // all block state holds while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            stg_q   <= '0;
            t_q     <= '0;
        end else if (en) begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            stg_q   <= stg_d;
            t_q     <= t_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign t_matrix = t_q;

endmodule

// File: tb/tb_t_block_param.sv
// tb_t_block_param: directed checks of the DH transform block in three lane/latency configurations
module tb_t_block_param;

    localparam int W = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic start6 = 1'b0, start2 = 1'b0, start1 = 1'b0;
    logic [W-1:0] a = '0, d = '0, ct = '0, st = '0, ca = '0, sa = '0;
    logic busy6, done6, busy2, done2, busy1, done1;
    logic [5:0][W-1:0] da6, db6, mr6;
    logic [1:0][W-1:0] da2, db2, mr2;
    logic [0:0][W-1:0] da1, db1, mr1;
    logic [1:0][5:0][W-1:0] mp6 = '0;
    logic [2:0][1:0][W-1:0] mp2 = '0;
    logic [1:0][0:0][W-1:0] mp1 = '0;
    logic [3:0][3:0][W-1:0] t6, t2, t1, exp_t;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // external multiplier: fixed-point product rescaled by 16, stalled by the same en
    function automatic logic [W-1:0] fmul(logic [W-1:0] x, logic [W-1:0] y);
        logic signed [2*W-1:0] p;
        p = $signed(x) * $signed(y);
        return p[W+15:16];
    endfunction

    always @(posedge clk) if (en) begin
        for (int j = 0; j < 6; j++) mp6[0][j] <= fmul(da6[j], db6[j]);
        mp6[1] <= mp6[0];
    end
    assign mr6 = mp6[1];

    always @(posedge clk) if (en) begin
        for (int j = 0; j < 2; j++) mp2[0][j] <= fmul(da2[j], db2[j]);
        mp2[1] <= mp2[0];
        mp2[2] <= mp2[1];
    end
    assign mr2 = mp2[2];

    always @(posedge clk) if (en) begin
        mp1[0][0] <= fmul(da1[0], db1[0]);
        mp1[1] <= mp1[0];
    end
    assign mr1 = mp1[1];

    t_block_param #(.W(W), .FRAC(16), .NUM_MULT(6), .MULT_LAT(2)) u6 (
        .clk(clk), .rst(rst), .en(en), .start(start6), .a(a), .d(d),
        .cos_theta(ct), .sin_theta(st), .cos_alpha(ca), .sin_alpha(sa),
        .busy(busy6), .done(done6), .mult_dataa(da6), .mult_datab(db6),
        .mult_result(mr6), .t_matrix(t6));

    t_block_param #(.W(W), .FRAC(16), .NUM_MULT(2), .MULT_LAT(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .a(a), .d(d),
        .cos_theta(ct), .sin_theta(st), .cos_alpha(ca), .sin_alpha(sa),
        .busy(busy2), .done(done2), .mult_dataa(da2), .mult_datab(db2),
        .mult_result(mr2), .t_matrix(t2));

    t_block_param #(.W(W), .FRAC(16), .NUM_MULT(1), .MULT_LAT(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .start(start1), .a(a), .d(d),
        .cos_theta(ct), .sin_theta(st), .cos_alpha(ca), .sin_alpha(sa),
        .busy(busy1), .done(done1), .mult_dataa(da1), .mult_datab(db1),
        .mult_result(mr1), .t_matrix(t1));

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [W-1:0] ia, id, ict, ist, ica, isa);
        a = ia; d = id; ct = ict; st = ist; ca = ica; sa = isa;
    endtask

    task automatic set_row(input int r, input logic [W-1:0] c0, c1, c2, c3);
        exp_t[r] = {c3, c2, c1, c0};
    endtask

    task automatic exp_mixed;
        set_row(0, 36'h30000, 36'hFFFFF0000, 36'h8000, 36'hC0000);
        set_row(1, 36'h20000, 36'h18000, 36'hFFFFF4000, 36'h80000);
        set_row(2, 36'h0, 36'h4000, 36'h8000, 36'h10000);
        set_row(3, 36'h0, 36'h0, 36'h0, 36'h10000);
    endtask

    task automatic exp_identity;
        set_row(0, 36'h10000, 36'h0, 36'h0, 36'h20000);
        set_row(1, 36'h0, 36'h10000, 36'h0, 36'h0);
        set_row(2, 36'h0, 36'h0, 36'h10000, 36'h30000);
        set_row(3, 36'h0, 36'h0, 36'h0, 36'h10000);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if ({busy6, busy2, busy1, done6, done2, done1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {busy6, busy2, busy1, done6, done2, done1});
        end
        checks++;
        if ({t6, t2, t1} !== '0) begin
            errors++;
            $display("FAIL reset_matrix got nonzero t6=%h", t6);
        end
        checks++;
        if ({da6, db6, da2, db2, da1, db1} !== '0) begin
            errors++;
            $display("FAIL reset_mult_data got nonzero lane0=%h", da6[0]);
        end
    endtask

    task automatic test_identity;
        exp_identity();
        set_in(36'h20000, 36'h30000, 36'h10000, 36'h0, 36'h10000, 36'h0);
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        set_in(36'h111, 36'h222, 36'h333, 36'h444, 36'h555, 36'h666);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (busy6 !== (c <= 4)) begin
                errors++;
                $display("FAIL id_busy cycle %0d got %b want %b", c, busy6, c <= 4);
            end
            checks++;
            if (done6 !== (c == 4)) begin
                errors++;
                $display("FAIL id_done cycle %0d got %b want %b", c, done6, c == 4);
            end
            if (c == 1) begin
                checks++;
                if (da6[2] !== 36'h20000 || db6[2] !== 36'h10000) begin
                    errors++;
                    $display("FAIL id_lane2 got %h*%h want 20000*10000", da6[2], db6[2]);
                end
            end
            if (c == 2) begin
                checks++;
                if ({da6, db6} !== '0) begin
                    errors++;
                    $display("FAIL id_idle_lanes got lane0 %h want 0", da6[0]);
                end
            end
            if (c == 3) begin
                checks++;
                if (t6 !== '0) begin
                    errors++;
                    $display("FAIL id_partial got %h want 0", t6);
                end
            end
            if (c == 4) begin
                checks++;
                if (t6 !== exp_t) begin
                    errors++;
                    $display("FAIL id_matrix got %h want %h", t6, exp_t);
                end
            end
            tick();
        end
    endtask

    task automatic test_lat3;
        set_row(0, 36'h0, 36'h0, 36'h10000, 36'h0);
        set_row(1, 36'h10000, 36'h0, 36'h0, 36'h10000);
        set_row(2, 36'h0, 36'h10000, 36'h0, 36'h8000);
        set_row(3, 36'h0, 36'h0, 36'h0, 36'h10000);
        set_in(36'h10000, 36'h8000, 36'h0, 36'h10000, 36'h0, 36'h10000);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        set_in(36'h777, 36'h777, 36'h777, 36'h777, 36'h777, 36'h777);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (busy2 !== (c <= 7)) begin
                errors++;
                $display("FAIL lat3_busy cycle %0d got %b want %b", c, busy2, c <= 7);
            end
            checks++;
            if (done2 !== (c == 7)) begin
                errors++;
                $display("FAIL lat3_done cycle %0d got %b want %b", c, done2, c == 7);
            end
            if (c == 2) begin
                checks++;
                if (da2[0] !== 36'h10000 || db2[0] !== 36'h0) begin
                    errors++;
                    $display("FAIL lat3_group1_lane0 got %h*%h want 10000*0", da2[0], db2[0]);
                end
            end
            if (c == 7) begin
                checks++;
                if (t2 !== exp_t) begin
                    errors++;
                    $display("FAIL lat3_matrix got %h want %h", t2, exp_t);
                end
            end
            tick();
        end
    endtask

    task automatic test_start_held;
        logic [W-1:0] ea [6];
        logic [W-1:0] eb [6];
        int dones;
        ea = '{36'h20000, 36'h20000, 36'h40000, 36'h30000, 36'h30000, 36'h40000};
        eb = '{36'h8000, 36'h4000, 36'h30000, 36'h8000, 36'h4000, 36'h20000};
        dones = 0;
        exp_mixed();
        set_in(36'h40000, 36'h10000, 36'h30000, 36'h20000, 36'h8000, 36'h4000);
        start1 = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            if (c <= 6) begin
                checks++;
                if (da1[0] !== ea[c-1] || db1[0] !== eb[c-1]) begin
                    errors++;
                    $display("FAIL held_lane0 group %0d got %h*%h want %h*%h", c - 1, da1[0], db1[0], ea[c-1], eb[c-1]);
                end
            end
            dones += done1 ? 1 : 0;
            if (c == 9) begin
                checks++;
                if (done1 !== 1'b1 || t1 !== exp_t) begin
                    errors++;
                    $display("FAIL held_done9 got done=%b t=%h want done=1 t=%h", done1, t1, exp_t);
                end
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL held_done_count got %0d want 1", dones);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL held_after_done got busy=%b done=%b want 0 0", busy1, done1);
        end
        tick();
        start1 = 1'b0;
        dones = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 1) begin
                checks++;
                if (busy1 !== 1'b1) begin
                    errors++;
                    $display("FAIL second_run_busy got %b want 1", busy1);
                end
            end
            dones += done1 ? 1 : 0;
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL second_run_dones got %0d want 1", dones);
        end
    endtask

    task automatic test_en_stall;
        exp_mixed();
        set_in(36'h40000, 36'h10000, 36'h30000, 36'h20000, 36'h8000, 36'h4000);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (done2 !== (c == 10) || busy2 !== (c <= 10)) begin
                errors++;
                $display("FAIL stall_flags cycle %0d got busy=%b done=%b want %b %b", c, busy2, done2, c <= 10, c == 10);
            end
            if (c == 10) begin
                checks++;
                if (t2 !== exp_t) begin
                    errors++;
                    $display("FAIL stall_matrix got %h want %h", t2, exp_t);
                end
            end
            en = !(c >= 2 && c <= 4);
            tick();
        end
        en = 1'b1;
    endtask

    task automatic test_rst_mid;
        exp_identity();
        set_in(36'h20000, 36'h30000, 36'h10000, 36'h0, 36'h10000, 36'h0);
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            checks++;
            if (done6 !== 1'b0 || busy6 !== 1'b0) begin
                errors++;
                $display("FAIL rst_abort cycle %0d got busy=%b done=%b want 0 0", c, busy6, done6);
            end
            tick();
        end
        checks++;
        if (t6 !== '0) begin
            errors++;
            $display("FAIL rst_matrix got %h want 0", t6);
        end
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        repeat (3) tick();
        checks++;
        if (done6 !== 1'b1 || t6 !== exp_t) begin
            errors++;
            $display("FAIL rst_rerun got done=%b t=%h want done=1 t=%h", done6, t6, exp_t);
        end
        tick();
    endtask

    task automatic test_wrap;
        set_in(36'h0, 36'h0, 36'h0, 36'h800000000, 36'h10000, 36'h0);
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        repeat (3) tick();
        checks++;
        if (done6 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got %b want 1", done6);
        end
        checks++;
        if (t6[0][1] !== 36'h800000000 || t6[1][0] !== 36'h800000000) begin
            errors++;
            $display("FAIL wrap_neg got t01=%h t10=%h want 800000000 800000000", t6[0][1], t6[1][0]);
        end
        checks++;
        if (t6[3][3] !== 36'h10000 || t6[0][0] !== 36'h0) begin
            errors++;
            $display("FAIL wrap_fixed got t33=%h t00=%h want 10000 0", t6[3][3], t6[0][0]);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_lat3();
        test_start_held();
        test_en_stall();
        test_rst_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t_block_param.md
# t_block_param

Parametrised Denavit–Hartenberg transform block for the full-Jacobian datapath. It builds one 4x4 homogeneous link transform from precomputed cos/sin of theta and alpha plus link lengths a and d. The six required products are time-multiplexed onto an external, shared array multiplier of configurable lane count and latency. The block sits under full_mat beside the existing transform stage and replaces it wherever the multiplier budget or the word width differs.

## Interface
- W, 36: fixed-point word width, two's complement
- FRAC, 16: fractional bits; ONE = 1 << FRAC
- NUM_MULT, 6: multiplier lanes used; must be 1, 2, 3 or 6 (elaboration error otherwise)
- MULT_LAT, 2: external multiplier latency in cycles, ≥1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global advance; 0 freezes all block state
- start  in  1  begin transform; sampled only in IDLE with en=1
- a, d  in  W  link length, link offset
- cos_theta, sin_theta, cos_alpha, sin_alpha  in  W  precomputed trig values
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when t_matrix is updated
- mult_dataa, mult_datab  out  NUM_MULT×W  operands per lane
- mult_result  in  NUM_MULT×W  products already rescaled by FRAC, valid MULT_LAT cycles after issue
- t_matrix  out  4×4×W  row-major [row][col], held between runs

## Operation
- Products: P0=st·ca, P1=st·sa, P2=a·ct, P3=ct·ca, P4=ct·sa, P5=a·st.
- NG = 6/NUM_MULT issue groups. Group g drives lane j with product g·NUM_MULT+j.
- Result matrix:
  - row0 = [ct, −P0, P1, P2]
  - row1 = [st, P3, −P4, P5]
  - row2 = [0, sa, ca, d]
  - row3 = [0, 0, 0, ONE]
- Negation is W-bit two's complement with wrap; −(−2^(W−1)) stays −2^(W−1).
- Inputs are latched into an operand register on start acceptance. Later input changes do not affect the run.
- States:
  - IDLE: start accepted here only.
  - ISSUE: group counter 0..NG−1.
  - DRAIN: waits MULT_LAT cycles for the last group.
  - DONE: single cycle, then back to IDLE.
- Transitions: IDLE→ISSUE on accepted start; ISSUE→DRAIN after group NG−1; DRAIN→DONE when the last result is captured; DONE→IDLE.
- Result capture uses a MULT_LAT-deep valid/group-tag shift register. Products land in a P0..P5 staging register. t_matrix is written in full only in DONE, so partial results are never visible.
- start while busy is ignored. start in DONE is ignored.
- mult_dataa/datab are zero outside ISSUE.

## Timing
- Start accepted at edge 0.
- Group g is driven on cycles 1+g.
- Group g's result is captured at edge 1+g+MULT_LAT.
- done and the t_matrix update occur in cycle NG+MULT_LAT+1. Default config: cycle 4.
- busy covers cycles 1 through NG+MULT_LAT+1 inclusive.
- en=0 holds FSM, counters, valid pipe, staging and outputs. Integration must stall the external multiplier with the same en.
- Reset values:
  - FSM = IDLE
  - busy = 0, done = 0
  - mult_data = 0
  - t_matrix all zero, including [3][3]
  - staging and valid pipe cleared
- rst mid-run aborts the run. No done is produced and t_matrix keeps its reset (zero) value. Any in-flight multiplier results are discarded.

## Structure
- Shared package t_block_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - product index enum P0..P5
  - operand-pair lookup function: index → (a-select, b-select)
  - ONE(FRAC) helper
- One sub-module t_block_issue_sched: group counter plus valid/tag shift register, parametrised by NUM_MULT and MULT_LAT. The top holds the operand latch, staging, matrix assembly and FSM.

## Test plan
- W=36, FRAC=16, NUM_MULT=6, MULT_LAT=2; ct=ca=0x10000, st=sa=0, a=0x20000, d=0x30000 → done at cycle 4; t = identity rotation, t[0][3]=0x20000, t[2][3]=0x30000, t[3][3]=0x10000.
- NUM_MULT=2, MULT_LAT=3; ct=ca=0, st=sa=0x10000, a=0x10000, d=0x8000 → rows [0,0,0x10000,0], [0x10000,0,0,0x10000], [0,0x10000,0,0x8000], [0,0,0,0x10000]; done at cycle 7; busy for cycles 1–7.
- NUM_MULT=1: start held high across a whole run → exactly one done; a start pulse in the cycle after done starts a second run; lane 0 shows products P0..P5 in order.
- en low for 3 cycles mid-ISSUE (multiplier model stalled likewise) → done delayed by exactly 3 cycles with identical t_matrix.
- rst pulsed in the DRAIN cycle → no done, t_matrix zero, busy 0; a following start completes normally.
- sin_theta = −2^35, cos_alpha = ONE → t[0][1] wraps to −2^35 per the negation rule.
